// File: rtl/transpose_drain_if.sv
// Read-side bundle of the transpose buffer: bank status and downstream handshake in,
// bank read port, row metadata and bank release out.
interface transpose_drain_if #(
    parameter int unsigned NUM_PE         = 8,
    parameter int unsigned ADDR_WIDTH     = $clog2(NUM_PE),
    parameter int unsigned SHIFT_AMT_BITS = 9
);
    logic [1:0]                      bank_full;
    logic                            out_ready;
    logic                            ren;
    logic [NUM_PE-1:0][ADDR_WIDTH:0] read_addr;
    logic                            out_val;
    logic                            out_last;
    logic [SHIFT_AMT_BITS-1:0]       out_shift_amt;
    logic                            bank_release;
    logic                            bank_release_sel;

    modport master (
        input  bank_full,
        input  out_ready,
        output ren,
        output read_addr,
        output out_val,
        output out_last,
        output out_shift_amt,
        output bank_release,
        output bank_release_sel
    );

    modport slave (
        output bank_full,
        output out_ready,
        input  ren,
        input  read_addr,
        input  out_val,
        input  out_last,
        input  out_shift_amt,
        input  bank_release,
        input  bank_release_sel
    );
endinterface

// File: rtl/transpose_drain_ctrl.sv
// Drains a filled ping-pong transpose bank row by row with per-PE skewed addresses,
// a registered un-rotate amount, valid/ready backpressure and a bank release pulse.
module transpose_drain_ctrl #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned NUM_PE         = 8,
    parameter int unsigned ADDR_WIDTH     = $clog2(NUM_PE),
    parameter int unsigned SHIFT_AMT_BITS = 9
) (
    input  logic              clk,
    input  logic              rst,
    transpose_drain_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_PE - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic                            rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0]           row_q, row_d;
    logic                            out_val_q, out_val_d;
    logic                            out_last_q, out_last_d;
    logic [SHIFT_AMT_BITS-1:0]       shift_q, shift_d;
    logic                            release_q, release_d;
    logic                            release_sel_q, release_sel_d;

    logic                            issue_c;
    logic                            last_issue_c;
    logic [NUM_PE-1:0][ADDR_WIDTH:0] read_addr_c;

    // A row may be read whenever the output stage is empty or being emptied this cycle.
    assign issue_c      = (state_q == DRAIN) && (!out_val_q || bus.out_ready);
    assign last_issue_c = issue_c && (row_q == LAST_ROW);

    // PE i holds row r of the matrix at bank row (r - i), so the read is skewed per PE.
    for (genvar g = 0; g < NUM_PE; g++) begin : g_addr
        assign read_addr_c[g] = {rd_bank_q, row_q - ADDR_WIDTH'(g)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank_q     <= 1'b0;
            row_q         <= '0;
            out_val_q     <= 1'b0;
            out_last_q    <= 1'b0;
            shift_q       <= '0;
            release_q     <= 1'b0;
            release_sel_q <= 1'b0;
        end else begin
            rd_bank_q     <= rd_bank_d;
            row_q         <= row_d;
            out_val_q     <= out_val_d;
            out_last_q    <= out_last_d;
            shift_q       <= shift_d;
            release_q     <= release_d;
            release_sel_q <= release_sel_d;
        end
    end

    // Bank fullness is only consulted when idle or on the final row of a bank.
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        row_d     = row_q;
        case (state_q)
            IDLE: begin
                if (bus.bank_full[rd_bank_q]) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_issue_c) begin
                    row_d     = '0;
                    rd_bank_d = ~rd_bank_q;
                    state_d   = bus.bank_full[~rd_bank_q] ? DRAIN : IDLE;
                end else if (issue_c) begin
                    row_d = row_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        out_val_d     = out_val_q;
        out_last_d    = out_last_q;
        shift_d       = shift_q;
        release_d     = 1'b0;
        release_sel_d = release_sel_q;
        if (issue_c) begin
            out_val_d  = 1'b1;
            out_last_d = (row_q == LAST_ROW);
            shift_d    = SHIFT_AMT_BITS'(32'(row_q) * DATA_WIDTH);
        end else if (bus.out_ready) begin
            out_val_d = 1'b0;
        end
        // Read data is already captured by the bank, so the bank can go back early.
        if (last_issue_c) begin
            release_d     = 1'b1;
            release_sel_d = rd_bank_q;
        end
    end

    assign bus.ren              = issue_c;
    assign bus.read_addr        = read_addr_c;
    assign bus.out_val          = out_val_q;
    assign bus.out_last         = out_last_q;
    assign bus.out_shift_amt    = shift_q;
    assign bus.bank_release     = release_q;
    assign bus.bank_release_sel = release_sel_q;
endmodule

// File: doc/transpose_drain_ctrl.md
Name: transpose_drain_ctrl

Overview:
- Read-side controller for the ping-pong transpose buffer. It drains a filled bank row by row.
- Each cycle it issues per-PE skewed read addresses, plus a registered shift amount that un-rotates the assembled row.
- It supports valid/ready backpressure from the downstream consumer.
- It returns each bank to the write side with a one-cycle release pulse once every row of that bank has been issued.

Parameters:
- DATA_WIDTH, 64: bits per PE word.
- NUM_PE, 8: PEs, which is also rows per bank; must be a power of two.
- ADDR_WIDTH, $clog2(NUM_PE): row-index width. Bank addresses are ADDR_WIDTH+1 bits, with the bank select as the MSB.
- SHIFT_AMT_BITS, 9: width of the shift amount; equals $clog2(DATA_WIDTH*NUM_PE).

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- bank_full, input, 2: per-bank full flags from the write side. Bit b high means bank b holds a complete matrix.
- out_ready, input, 1: downstream accepts the current row.
- ren, output, 1: bank read enable, shared by all PEs.
- read_addr, output, [ADDR_WIDTH:0] x NUM_PE: per-PE read address, {rd_bank, row - i}.
- out_val, output, 1: bank read data and out_shift_amt are valid.
- out_last, output, 1: the current valid row is the final row of its bank.
- out_shift_amt, output, SHIFT_AMT_BITS: rotate amount for the current valid row.
- bank_release, output, 1: one-cycle pulse; the bank named by bank_release_sel may be overwritten.
- bank_release_sel, output, 1: index of the released bank.

Behaviour:
- Bank and data contract:
  - Clock, reset and handshake: one clock; reset is synchronous and active-high.
  - Read latency: banks have 1-cycle read latency and hold their output data while ren=0.
- Internal state:
  - rd_bank, reset 0.
  - row counter, ADDR_WIDTH bits, reset 0.
  - FSM state IDLE/DRAIN, reset IDLE.
- Reset values: ren=0, out_val=0, out_last=0, out_shift_amt=0, bank_release=0, bank_release_sel=0.
- Issue condition: issue = (state==DRAIN) && (!out_val || out_ready). ren = issue, combinational.
- Addressing:
  - read_addr[i] = {rd_bank, row - i}, computed modulo NUM_PE, combinational from the current state.
  - Addresses are driven even when ren=0.
- Output registers:
  - On issue, the following are set on the next edge: out_val<=1, out_shift_amt<=row*DATA_WIDTH (truncated to SHIFT_AMT_BITS), out_last<=(row==NUM_PE-1).
  - When !issue && out_ready, out_val<=0.
  - When out_val && !out_ready, out_val, out_shift_amt and out_last hold.
  - Read-to-out_val latency is 1 cycle.
- FSM transitions:
  - IDLE -> DRAIN when bank_full[rd_bank]=1. No read is issued in the transition cycle.
  - In DRAIN, each issue increments row.
  - On the issue with row==NUM_PE-1:
    - row<=0.
    - bank_release<=1 for one cycle, with bank_release_sel<=rd_bank.
    - rd_bank<=~rd_bank.
    - Next state is DRAIN if bank_full[~rd_bank]=1, else IDLE. Back-to-back banks therefore drain with no bubble.
- bank_full is sampled only in IDLE and on the final issue. It is never re-checked mid-drain.
  - A bank whose full flag drops mid-drain continues to drain; this is write-side misuse and is undefined.
- Throughput: with out_ready held high, one row per cycle and NUM_PE consecutive out_val cycles per bank.
- Stall: while out_ready=0 and out_val=1, ren=0 and the row counter freezes.
- Release timing: bank_release is asserted the cycle after the last read is issued, before the last row is accepted. This is safe because the bank data is already captured in the read output.
- Reset mid-drain: all state returns to reset values, the partial bank is abandoned, and no release is pulsed.

Test Plan:
- Single bank, ready always high:
  - Stimulus: bank_full=01 from cycle 2.
  - Response: IDLE->DRAIN, then ren high 8 cycles with rows 0..7.
  - read_addr[3] at row 1 = {0,3'd6}.
  - out_val high 8 cycles, one cycle after ren.
  - out_shift_amt = 0, 64, 128, ... 448.
  - out_last only on the 8th; bank_release pulses once with sel=0.
  - FSM returns to IDLE.
- Back-to-back banks:
  - Stimulus: bank_full=11.
  - Response: 16 contiguous out_val cycles.
  - Release pulses with sel=0 then sel=1, 8 cycles apart.
  - read_addr MSB flips after row 7 with no bubble.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles while row 2 is valid.
  - Response: ren=0, row, out_shift_amt=128 and out_last stay stable.
  - When ready returns, row 3 issues the same cycle; no row is lost or duplicated.
- Wrap addressing, row 0: read_addr[i] = {b, (0-i) mod 8}, so PE7 reads row 1 and PE1 reads row 7.
- Reset mid-drain:
  - Stimulus: assert rst at row 5.
  - Response: next cycle all outputs are 0 and rd_bank=0; no bank_release.
  - With bank_full=01 held, draining restarts at row 0.
- Empty:
  - Stimulus: bank_full=00 for 20 cycles.
  - Response: ren=0, out_val=0, no release.
  - When bank_full=10 while rd_bank=0, nothing issues until bank 0 fills.
